// File: rtl/lpc_packetizer.sv
// ---------------------------------------------------------------------------
// lpc_packetizer
//
// Buffers decoded LPC transactions in a small FIFO and serializes each one as
// a fixed 10-byte packet for a byte-wide consumer (typically a UART
// transmitter).
//
// Packet layout, in transmission order:
//   0xA5, {1'b0, size[2:0], cyctype_dir[3:0]},
//   addr[31:24], addr[23:16], addr[15:8], addr[7:0],
//   data[31:24], data[23:16], data[15:8], data[7:0]
//
// Ports
//   lpc_clock       single clock, all logic on the rising edge
//   lpc_reset       asynchronous, active-high reset
//   in_cyctype_dir  decoded cycle type / direction
//   in_addr         decoded address (I/O addresses zero-extended)
//   in_data         decoded data
//   in_data_size    transfer size in bytes (1, 2 or 4)
//   in_strobe       one-cycle pulse marking the in_* fields valid
//   out_byte        current stream byte
//   out_valid       out_byte is valid
//   out_ready       consumer accepts out_byte on this edge
//   overflow        sticky: at least one transaction was dropped
//   drop_count      number of dropped transactions, saturating at 255
//
// Total buffering is FIFO_DEPTH queued entries plus the packet currently
// held in the output shift register.
// ---------------------------------------------------------------------------
module lpc_packetizer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic [3:0]  in_cyctype_dir,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [2:0]  in_data_size,
  input  logic        in_strobe,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 4 + 3 + 32 + 32;
  localparam int PKT_W   = 80;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  // Entry layout: {cyctype_dir[70:67], size[66:64], addr[63:32], data[31:0]}
  function automatic logic [PKT_W-1:0] build_packet(input logic [ENTRY_W-1:0] e);
    return {8'hA5, 1'b0, e[66:64], e[70:67], e[63:32], e[31:0]};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // FIFO storage and pointers. Pointers carry one extra wrap bit so that a
  // full FIFO (same index, different wrap) is distinct from an empty one.
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic               drop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  // Serializer state
  state_t             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [PKT_W-1:0]   pkt_q, pkt_d;

  // Drop accounting
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Fullness is judged on the registered pointers, so a pop on the same edge
  // cannot make room for a strobe that arrives while the FIFO is full.
  assign push     = in_strobe && !fifo_full;
  assign drop     = in_strobe &&  fifo_full;
  assign wr_entry = {in_cyctype_dir, in_data_size, in_addr, in_data};
  assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

  // Storage array carries no reset; the pointers alone define its contents.
  always_ff @(posedge lpc_clock) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end
  end

  // Serializer next-state logic. The packet is held in an 80-bit shift
  // register whose top byte drives out_byte; each accepted byte shifts it
  // left by eight bits.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pkt_d   = pkt_q;
    pop     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_SEND;
          idx_d   = 4'd0;
          pkt_d   = build_packet(rd_entry);
        end
      end

      S_SEND: begin
        if (out_ready) begin
          if (idx_q == 4'd9) begin
            idx_d = 4'd0;
            if (!fifo_empty) begin
              // Chain straight into the next packet with no idle cycle.
              pop   = 1'b1;
              pkt_d = build_packet(rd_entry);
            end else begin
              state_d = S_IDLE;
              pkt_d   = '0;
            end
          end else begin
            idx_d = idx_q + 4'd1;
            pkt_d = {pkt_q[PKT_W-9:0], 8'h00};
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = 4'd0;
        pkt_d   = '0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
  end

  always_ff @(posedge lpc_clock or posedge lpc_reset) begin
    if (lpc_reset) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      pkt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pkt_q      <= pkt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // All outputs come straight from registers; out_valid has no path from
  // out_ready.
  assign out_valid  = (state_q == S_SEND);
  assign out_byte   = pkt_q[PKT_W-1 -: 8];
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_lpc_packetizer.sv
module tb_lpc_packetizer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  in_cyctype_dir = '0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic [2:0]  in_data_size = '0;
  logic        in_strobe = 1'b0;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int strobe_edge = 0;

  logic [7:0] exp_q[$];
  int         xfer_edges[$];

  lpc_packetizer #(.FIFO_DEPTH(4)) dut (
    .lpc_clock      (clk),
    .lpc_reset      (rst),
    .in_cyctype_dir (in_cyctype_dir),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .in_data_size   (in_data_size),
    .in_strobe      (in_strobe),
    .out_byte       (out_byte),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .overflow       (overflow),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  task automatic push_pkt(input logic [3:0] c, input logic [2:0] s,
                          input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back(8'hA5);
    exp_q.push_back({1'b0, s, c});
    exp_q.push_back(a[31:24]); exp_q.push_back(a[23:16]);
    exp_q.push_back(a[15:8]);  exp_q.push_back(a[7:0]);
    exp_q.push_back(d[31:24]); exp_q.push_back(d[23:16]);
    exp_q.push_back(d[15:8]);  exp_q.push_back(d[7:0]);
  endtask

  // Drives one strobe, capturing at the next rising edge. Called at posedge+1.
  task automatic do_strobe(input logic [3:0] c, input logic [2:0] s,
                           input logic [31:0] a, input logic [31:0] d,
                           input bit expect_out);
    if (expect_out) push_pkt(c, s, a, d);
    in_cyctype_dir = c; in_data_size = s; in_addr = a; in_data = d;
    in_strobe = 1'b1;
    @(posedge clk); #1;
    strobe_edge = cyc;
    in_strobe = 1'b0;
  endtask

  task automatic drain(input string name, input bit toggle, input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk); #1;
      if (toggle) out_ready = ~out_ready;
      n++;
    end
    if (exp_q.size() != 0) chk({name, "_drain_timeout"}, exp_q.size(), 0);
    chk({name, "_valid_after"}, out_valid, 1'b0);
    out_ready = 1'b1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_byte", out_byte, 8'h00);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_drop_count", drop_count, 8'd0);
    exp_q.delete();
    xfer_edges.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: sampled on the falling edge, where out_valid/out_ready hold the
  // values the next rising edge will see.
  logic       stall_pend = 1'b0;
  logic [7:0] held_byte  = '0;
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_byte", out_byte, held_byte);
      end
      if (out_valid && out_ready) begin
        xfer_edges.push_back(cyc + 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", out_byte, 32'hFFFF_FFFF);
        end else begin
          chk("byte", out_byte, exp_q.pop_front());
        end
      end
      stall_pend = out_valid && !out_ready;
      held_byte  = out_byte;
    end
  end

  initial begin
    int n;
    #2;
    apply_reset();

    // Single memory read, ready held high.
    xfer_edges.delete();
    do_strobe(4'h0, 3'd1, 32'h0000_7FE5, 32'h0000_006C, 1'b1);
    drain("t_single", 1'b0, 40);
    chk("t_single_count", xfer_edges.size(), 10);
    if (xfer_edges.size() == 10) begin
      chk("t_single_latency", xfer_edges[0], strobe_edge + 2);
      chk("t_single_span", xfer_edges[9] - xfer_edges[0], 9);
    end

    // Two reads three cycles apart: 20 bytes with no gap.
    xfer_edges.delete();
    do_strobe(4'h0, 3'd1, 32'h0000_7FE5, 32'h0000_006C, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    do_strobe(4'h0, 3'd1, 32'h0000_7FE5, 32'h0000_006C, 1'b1);
    drain("t_pair", 1'b0, 60);
    chk("t_pair_count", xfer_edges.size(), 20);
    if (xfer_edges.size() == 20)
      chk("t_pair_span", xfer_edges[19] - xfer_edges[0], 19);

    // Ready toggling every cycle; the monitor checks bytes hold while stalled.
    out_ready = 1'b0;
    xfer_edges.delete();
    do_strobe(4'h0, 3'd1, 32'h0000_7FE5, 32'h0000_006C, 1'b1);
    drain("t_toggle", 1'b1, 60);
    chk("t_toggle_count", xfer_edges.size(), 10);
    chk("t_clean_overflow", overflow, 1'b0);
    chk("t_clean_drops", drop_count, 8'd0);

    // Six back-to-back strobes with the consumer stalled: five fit, one drops.
    out_ready = 1'b0;
    xfer_edges.delete();
    for (int i = 0; i < 6; i++)
      do_strobe(4'h2, 3'd4, 32'h0000_1000 + i, 32'hCAFE_0000 + i, i < 5);
    chk("t_six_overflow", overflow, 1'b1);
    chk("t_six_drops", drop_count, 8'd1);
    chk("t_six_valid_stalled", out_valid, 1'b1);
    out_ready = 1'b1;
    drain("t_six", 1'b0, 100);
    chk("t_six_count", xfer_edges.size(), 50);
    chk("t_six_overflow_sticky", overflow, 1'b1);

    // 300 strobes while stalled: count saturates at 255.
    apply_reset();
    out_ready = 1'b0;
    xfer_edges.delete();
    for (int i = 0; i < 300; i++)
      do_strobe(4'h3, 3'd2, 32'h0000_0080 + i, 32'h0000_BE00 + i, i < 5);
    chk("t_sat_drops", drop_count, 8'd255);
    chk("t_sat_overflow", overflow, 1'b1);
    out_ready = 1'b1;
    drain("t_sat", 1'b0, 100);
    chk("t_sat_count", xfer_edges.size(), 50);
    chk("t_sat_drops_held", drop_count, 8'd255);

    // Reset in the middle of a packet with a second entry queued.
    apply_reset();
    out_ready = 1'b1;
    xfer_edges.delete();
    do_strobe(4'h1, 3'd4, 32'h1122_3344, 32'h5566_7788, 1'b1);
    do_strobe(4'h1, 3'd4, 32'h99AA_BBCC, 32'hDDEE_FF00, 1'b1);
    n = 0;
    while (xfer_edges.size() < 4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t_rst_reached_byte4", xfer_edges.size(), 4);
    chk("t_rst_byte4_shown", out_byte, 8'h33);
    rst = 1'b1;
    #1;
    chk("t_rst_async_valid", out_valid, 1'b0);
    chk("t_rst_async_byte", out_byte, 8'h00);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    xfer_edges.delete();
    repeat (25) begin @(posedge clk); #1; end
    chk("t_rst_no_bytes", xfer_edges.size(), 0);
    chk("t_rst_idle_valid", out_valid, 1'b0);
    do_strobe(4'h0, 3'd1, 32'h0000_7FE5, 32'h0000_006C, 1'b1);
    drain("t_rst_after", 1'b0, 40);
    chk("t_rst_after_count", xfer_edges.size(), 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
